// File: rtl/stdp_pair_learner.sv
// Pair-based STDP synapse: times the gap between the nearest pre/post spike
// pair with a saturating counter, then nudges an 8-bit weight up (pre before
// post) or down (post before pre) by a step that halves every quarter window.
// Also drives the synaptic current seen by the postsynaptic neuron.
module stdp_pair_learner #(
  parameter int WIDTH  = 8,
  parameter int CW     = 4,
  parameter int A_MAX  = 16,
  parameter int W_INIT = 128
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_learn_en,
  input  logic             i_pre_spike,
  input  logic             i_post_spike,
  output logic [WIDTH-1:0] o_weight,
  output logic [WIDTH-1:0] o_syn_current,
  output logic             o_update_valid,
  output logic             o_update_dir,
  output logic [CW-1:0]    o_time_diff
);

  // All-ones counter value marks the edge of the timing window.
  localparam logic [CW-1:0] TWIN = '1;

  typedef enum logic [1:0] {IDLE, PRE_WAIT, POST_WAIT, UPDATE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [CW-1:0]    r_dt, w_dt_nxt;
  logic             r_dir, w_dir_nxt;
  logic [WIDTH-1:0] r_weight;
  logic [WIDTH-1:0] r_syn;
  logic             r_upd_valid;
  logic             r_upd_dir;
  logic [CW-1:0]    r_time_diff;

  logic [CW-1:0]    w_shift;
  logic [WIDTH:0]   w_dw;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_weight_upd;

  // Next-state logic: open a pairing on a lone spike, close it on the
  // opposite spike, restart on a repeat of the opening spike, time out at TWIN.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dt_nxt    = r_dt;
    w_dir_nxt   = r_dir;
    case (r_state)
      IDLE: begin
        // Coincident pre+post means dt=0, which is defined as no change.
        if (i_pre_spike && !i_post_spike) begin
          w_state_nxt = PRE_WAIT;
          w_cnt_nxt   = CW'(1);
        end else if (i_post_spike && !i_pre_spike) begin
          w_state_nxt = POST_WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end
      PRE_WAIT: begin
        // Closing spike wins over a simultaneous restart of the opener.
        if (i_post_spike) begin
          w_state_nxt = UPDATE;
          w_dt_nxt    = r_cnt;
          w_dir_nxt   = 1'b1;
        end else if (i_pre_spike) begin
          w_cnt_nxt   = CW'(1);
        end else if (r_cnt == TWIN) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      POST_WAIT: begin
        if (i_pre_spike) begin
          w_state_nxt = UPDATE;
          w_dt_nxt    = r_cnt;
          w_dir_nxt   = 1'b0;
        end else if (i_post_spike) begin
          w_cnt_nxt   = CW'(1);
        end else if (r_cnt == TWIN) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
      end
      UPDATE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Step size halves per quarter of the window; add/subtract one bit wider
  // so overflow and underflow are visible and clamped instead of wrapping.
  always_comb begin
    w_shift      = r_dt >> (CW - 2);
    w_dw         = (WIDTH + 1)'(A_MAX) >> w_shift;
    w_sum        = {1'b0, r_weight} + w_dw;
    w_diff       = {1'b0, r_weight} - w_dw;
    w_weight_upd = r_weight;
    if (r_dir)
      w_weight_upd = w_sum[WIDTH] ? '1 : w_sum[WIDTH-1:0];
    else
      w_weight_upd = w_diff[WIDTH] ? '0 : w_diff[WIDTH-1:0];
  end

  // State, counter, weight and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_dt        <= '0;
      r_dir       <= 1'b0;
      r_weight    <= WIDTH'(W_INIT);
      r_syn       <= '0;
      r_upd_valid <= 1'b0;
      r_upd_dir   <= 1'b0;
      r_time_diff <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dt        <= w_dt_nxt;
      r_dir       <= w_dir_nxt;
      // Current uses the weight before any same-edge update.
      r_syn       <= i_pre_spike ? r_weight : '0;
      r_upd_valid <= (r_state == UPDATE);
      if (r_state == UPDATE) begin
        r_upd_dir   <= r_dir;
        r_time_diff <= r_dt;
        if (i_learn_en)
          r_weight <= w_weight_upd;
      end
    end
  end

  assign o_weight       = r_weight;
  assign o_syn_current  = r_syn;
  assign o_update_valid = r_upd_valid;
  assign o_update_dir   = r_upd_dir;
  assign o_time_diff    = r_time_diff;

endmodule

// File: tb/tb_stdp_pair_learner.sv
// Bench for stdp_pair_learner: directed scenarios followed by random spike
// trains, all checked every cycle against a spike-time reference model.
module tb_stdp_pair_learner;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1, i_learn_en = 1'b1, i_pre_spike = 1'b0, i_post_spike = 1'b0;
  logic [7:0] o_weight, o_syn_current;
  logic       o_update_valid, o_update_dir;
  logic [3:0] o_time_diff;

  int checks = 0;
  int errors = 0;

  // Reference model: remembers which spike is open and when it happened.
  int m_open;     // 0 none, 1 pre open, 2 post open
  int m_t0;       // edge index of the open spike
  int m_t;        // current edge index
  bit m_pend;     // pairing resolved, update due at next edge
  int m_pdt;
  bit m_pdir;
  int m_w;
  int e_syn;
  bit e_valid;
  bit e_dir;
  int e_td;

  always #5 clk = ~clk;

  stdp_pair_learner dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_learn_en    (i_learn_en),
    .i_pre_spike   (i_pre_spike),
    .i_post_spike  (i_post_spike),
    .o_weight      (o_weight),
    .o_syn_current (o_syn_current),
    .o_update_valid(o_update_valid),
    .o_update_dir  (o_update_dir),
    .o_time_diff   (o_time_diff)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic int step_size(input int dt);
    return 16 >> (dt / 4);
  endfunction

  // Advance the model by one clock edge given the inputs sampled there.
  task automatic model_edge(input bit rst, input bit pre, input bit post, input bit le);
    m_t++;
    if (rst) begin
      m_open = 0; m_pend = 0; m_w = 128;
      e_syn = 0; e_valid = 0; e_dir = 0; e_td = 0;
      return;
    end
    e_syn   = pre ? m_w : 0;
    e_valid = 0;
    if (m_pend) begin
      m_pend  = 0;
      e_valid = 1; e_dir = m_pdir; e_td = m_pdt;
      if (le) begin
        if (m_pdir) m_w = (m_w + step_size(m_pdt) > 255) ? 255 : m_w + step_size(m_pdt);
        else        m_w = (m_w - step_size(m_pdt) < 0)   ? 0   : m_w - step_size(m_pdt);
      end
    end else if (m_open == 0) begin
      if (pre != post) begin m_open = pre ? 1 : 2; m_t0 = m_t; end
    end else begin
      bit closer = (m_open == 1) ? post : pre;
      bit opener = (m_open == 1) ? pre  : post;
      if (closer) begin
        m_pend = 1; m_pdt = m_t - m_t0; m_pdir = (m_open == 1); m_open = 0;
      end else if (opener) begin
        m_t0 = m_t;
      end else if (m_t - m_t0 >= 15) begin
        m_open = 0;
      end
    end
  endtask

  task automatic step(input bit rst, input bit pre, input bit post, input bit le);
    i_rst = rst; i_pre_spike = pre; i_post_spike = post; i_learn_en = le;
    @(posedge clk);
    model_edge(rst, pre, post, le);
    #1;
    chk("weight", o_weight, m_w);
    chk("syn_current", o_syn_current, e_syn);
    chk("update_valid", o_update_valid, e_valid);
    if (e_valid) begin
      chk("update_dir", o_update_dir, e_dir);
      chk("time_diff", o_time_diff, e_td);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
  endtask

  initial begin
    m_t = 0; m_open = 0; m_pend = 0; m_w = 128;
    e_syn = 0; e_valid = 0; e_dir = 0; e_td = 0;

    // Reset values
    do_reset();
    chk("rst_weight", o_weight, 128);
    chk("rst_syn", o_syn_current, 0);
    chk("rst_valid", o_update_valid, 0);
    chk("rst_td", o_time_diff, 0);
    chk("rst_dir", o_update_dir, 0);

    // LTP: pre at edge 0, post at edge 3
    step(0, 1, 0, 1); idle(2); step(0, 0, 1, 1); idle(1);
    chk("ltp_valid", o_update_valid, 1);
    chk("ltp_dir", o_update_dir, 1);
    chk("ltp_td", o_time_diff, 3);
    chk("ltp_w", o_weight, 144);
    idle(1);
    chk("ltp_valid_drop", o_update_valid, 0);

    // LTD: post at edge 0, pre at edge 6
    do_reset();
    step(0, 0, 1, 1); idle(5); step(0, 1, 0, 1);
    chk("ltd_syn_preupd", o_syn_current, 128);
    idle(1);
    chk("ltd_td", o_time_diff, 6);
    chk("ltd_dir", o_update_dir, 0);
    chk("ltd_w", o_weight, 120);
    idle(2);

    // Timeout: post 16 edges after pre opens a new LTD window
    do_reset();
    step(0, 1, 0, 1); idle(15); step(0, 0, 1, 1); idle(1);
    chk("to_valid", o_update_valid, 0);
    chk("to_w", o_weight, 128);
    idle(1); step(0, 1, 0, 1); idle(1);
    chk("to_reopen_w", o_weight, 112);
    idle(2);

    // Restart: pre at 0 and 5, post at 7
    do_reset();
    step(0, 1, 0, 1); idle(4); step(0, 1, 0, 1); idle(1); step(0, 0, 1, 1); idle(1);
    chk("rs_td", o_time_diff, 2);
    chk("rs_w", o_weight, 144);
    idle(2);

    // Upper clamp, then learning disabled
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(0, 1, 0, 1); step(0, 0, 1, 1); step(0, 0, 0, 1);
    end
    chk("sat_hi", o_weight, 255);
    step(0, 0, 1, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
    chk("nolearn_valid", o_update_valid, 1);
    chk("nolearn_dir", o_update_dir, 0);
    chk("nolearn_w", o_weight, 255);
    idle(2);

    // Lower clamp
    for (int k = 0; k < 18; k++) begin
      step(0, 0, 1, 1); step(0, 1, 0, 1); step(0, 0, 0, 1);
    end
    chk("sat_lo", o_weight, 0);

    // Simultaneous spikes in IDLE
    do_reset();
    step(0, 1, 1, 1); idle(4);
    chk("simul_w", o_weight, 128);

    // Reset mid-pairing at cnt=5, then post
    do_reset();
    step(0, 1, 0, 1); idle(4); step(1, 0, 0, 1); step(0, 0, 1, 1); idle(2);
    chk("rstmid_w", o_weight, 128);
    chk("rstmid_valid", o_update_valid, 0);
    idle(16);

    // Random spike trains with varying density
    for (int blk = 0; blk < 30; blk++) begin
      int dens = (blk % 3 == 0) ? 2 : ((blk % 3 == 1) ? 6 : 20);
      for (int c = 0; c < 80; c++) begin
        bit pre  = ($urandom_range(0, dens - 1) == 0);
        bit post = ($urandom_range(0, dens - 1) == 0);
        bit le   = ($urandom_range(0, 7) != 0);
        bit rst  = ($urandom_range(0, 299) == 0);
        step(rst, pre, post, le);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stdp_pair_learner.md
Name: stdp_pair_learner

Overview:
- Consumes the spike outputs of the pre- and postsynaptic LIF neurons.
- Measures pre/post spike timing with a saturating counter.
- Applies a nearest-neighbour, pair-based STDP rule to an 8-bit synaptic weight:
  - LTP when pre precedes post.
  - LTD when post precedes pre.
- Also drives the weighted synaptic current (weight gated by the pre spike), which is the post neuron's input.

Parameters:
- WIDTH, 8: weight and current width.
- CW, 4: timing counter width; timing window TWIN = 2^CW-1 = 15 cycles.
- A_MAX, 16: maximum weight step, applied at the smallest time difference.
- W_INIT, 128: weight value after reset.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- learn_en  in  1  when low, pairings still complete but weight is not modified.
- pre_spike  in  1  presynaptic spike; 1-cycle pulse per spike.
- post_spike  in  1  postsynaptic spike; 1-cycle pulse per spike.
- weight  out  WIDTH  current synaptic weight.
- syn_current  out  WIDTH  weight if pre_spike was high at the previous edge, else 0.
- update_valid  out  1  1-cycle pulse when a pairing is resolved.
- update_dir  out  1  1 = LTP, 0 = LTD; valid with update_valid.
- time_diff  out  CW  dt of the resolved pairing; valid with update_valid.

Behaviour:
- Reset (rst high at an edge):
  - state=IDLE, cnt=0, weight=W_INIT.
  - syn_current=0, update_valid=0, update_dir=0, time_diff=0.
  - Reset mid-pairing discards the pairing; no update.
- syn_current is registered every edge: pre_spike ? weight : 0. The weight used is the pre-update value when the two coincide.
- FSM states: IDLE, PRE_WAIT, POST_WAIT, UPDATE.
- IDLE:
  - pre only -> PRE_WAIT, cnt=1.
  - post only -> POST_WAIT, cnt=1.
  - pre and post in the same cycle -> stay IDLE, no update (dt=0 is defined as no change).
- PRE_WAIT:
  - post (with or without pre) -> UPDATE: dt_reg=cnt, dir=LTP. The pairing wins; a simultaneous pre is discarded.
  - pre only -> restart, cnt=1 (nearest pre kept).
  - no spike and cnt==TWIN -> IDLE, no update (timeout).
  - otherwise cnt=cnt+1.
- POST_WAIT: mirror of PRE_WAIT:
  - pre -> UPDATE with dir=LTD.
  - post restarts cnt=1.
  - timeout at TWIN -> IDLE.
- UPDATE (exactly one cycle), at the next edge:
  - update_valid=1, update_dir=dir, time_diff=dt_reg.
  - weight updated if learn_en=1.
  - state -> IDLE.
  - Spikes arriving during UPDATE are ignored.
- Step size: dw = A_MAX >> (dt_reg >> (CW-2)). With defaults:
  - dt 1-3 -> 16
  - dt 4-7 -> 8
  - dt 8-11 -> 4
  - dt 12-15 -> 2
- Arithmetic:
  - LTP: weight = min(weight+dw, 2^WIDTH-1).
  - LTD: weight = max(weight-dw, 0).
  - Compute in WIDTH+1 bits; must never wrap.
- Latency: closing spike sampled at edge k -> weight, update_valid and time_diff visible after edge k+1. update_valid deasserts after edge k+2.
- learn_en is sampled in the UPDATE cycle only. With learn_en=0, update_valid, update_dir and time_diff still report the pairing.
- Counter saturates; it never wraps past TWIN.

Test Plan:
- Reset: assert rst 2 cycles -> weight=128, syn_current=0, update_valid=0, time_diff=0.
- LTP: pre at edge 0, post at edge 3 -> after edge 4: update_valid=1, update_dir=1, time_diff=3, weight=144.
- LTD: post at edge 0, pre at edge 6 -> time_diff=6, update_dir=0, weight=120. Also check syn_current=128 the cycle after the pre spike (pre-update weight).
- Timeout and restart:
  - pre at edge 0, post at edge 16 -> no update; weight stays 128; the post opens POST_WAIT.
  - pre at edges 0 and 5, post at edge 7 -> time_diff=2, weight=144.
- Saturation: 16 back-to-back LTP pairings with dt=1 -> weight clamps at 255.
  - Then learn_en=0 with an LTD pairing -> update_valid pulses, weight stays 255.
- Edge cases:
  - Simultaneous pre+post in IDLE -> no update.
  - rst asserted in PRE_WAIT at cnt=5, then post -> weight=128, no update_valid.
